// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, accumulator FSM encoding and the operand extend helper
package pe_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 40;
  localparam int CNT_W_DEF  = 8;
  localparam int EXT_W      = 64;
  localparam int EXT_IW     = $clog2(EXT_W);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1
  } state_e;
  // Widens the low w bits of d to EXT_W, replicating bit w-1 when sgn is set;
  // callers truncate the result to their own accumulator width.
  function automatic logic [EXT_W-1:0] ext_fn(input logic [EXT_W-1:0] d, input int w, input logic sgn);
    logic [EXT_W-1:0] r;
    r = '0;
    for (int i = 0; i < EXT_W; i++)
      r[EXT_IW'(i)] = (i < w) ? d[EXT_IW'(i)] : (sgn & d[EXT_IW'(w - 1)]);
    return r;
  endfunction
endpackage

// File: rtl/pe_mul_accum_if.sv
// pe_mul_accum_if: product input stream and group-sum output stream
interface pe_mul_accum_if #(
  parameter int DATA_W = pe_pkg::DATA_W_DEF,
  parameter int ACC_W  = pe_pkg::ACC_W_DEF,
  parameter int CNT_W  = pe_pkg::CNT_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_signed;
  logic [CNT_W-1:0]  cfg_len;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  modport master (
    output in_valid, in_data, in_signed, cfg_len, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );
  modport slave (
    input  in_valid, in_data, in_signed, cfg_len, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/pe_accum_out_reg.sv
// pe_accum_out_reg: 1-deep valid/ready holding register for finished group sums
module pe_accum_out_reg #(
  parameter int ACC_W = pe_pkg::ACC_W_DEF,
  parameter int CNT_W = pe_pkg::CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             clk_en,
  input  logic             load_i,
  input  logic [ACC_W-1:0] data_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [ACC_W-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);
  logic             valid_q, valid_d;
  logic [ACC_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  // A load wins over a drain so a sum arriving on the drain edge keeps valid high
  always_comb begin
    valid_d = load_i ? 1'b1 : (valid_q & ready_i) ? 1'b0 : valid_q;
    data_d  = load_i ? data_i : data_q;
    count_d = load_i ? count_i : count_q;
  end
  // Output register, frozen while clk_en is low
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else if (clk_en) begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;
endmodule

// File: rtl/pe_mul_accum.sv
// pe_mul_accum: sums groups of cfg_len PE products and emits each group sum
module pe_mul_accum
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          clk_en,
  pe_mul_accum_if.slave bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] eff_len;
  logic [ACC_W-1:0] ext, sum;
  logic             first, last, in_rdy, in_fire, out_valid;
  // cfg_len is only honoured on the first beat; later beats use the latched length
  assign ext     = ACC_W'(ext_fn(EXT_W'(bus.in_data), DATA_W, bus.in_signed));
  assign first   = state_q == ST_IDLE;
  assign eff_len = first ? ((bus.cfg_len == '0) ? CNT_W'(1) : bus.cfg_len) : len_q;
  assign last    = (beat_cnt_q + CNT_W'(1)) == eff_len;
  assign sum     = first ? ext : acc_q + ext;
  // Only a closing beat can stall, and only while the previous sum is stuck
  assign in_rdy       = clk_en & ~(last & out_valid & ~bus.out_ready);
  assign in_fire      = clk_en & bus.in_valid & in_rdy;
  assign bus.in_ready = in_rdy;
  assign bus.out_valid = out_valid;
  // Next-state: accepted beats advance the group, the closing beat returns to idle
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    acc_d      = acc_q;
    if (in_fire) begin
      state_d    = last ? ST_IDLE : ST_ACCUM;
      beat_cnt_d = last ? '0 : beat_cnt_q + CNT_W'(1);
      len_d      = eff_len;
      acc_d      = last ? '0 : sum;
    end
  end
  // Group state registers; a reset drops any partial sum
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      len_q      <= '0;
      acc_q      <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
    end
  end
  pe_accum_out_reg #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_out (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clk_en  (clk_en),
    .load_i  (in_fire & last),
    .data_i  (sum),
    .count_i (eff_len),
    .ready_i (bus.out_ready),
    .valid_o (out_valid),
    .data_o  (bus.out_data),
    .count_o (bus.out_count)
  );
endmodule

// File: tb/tb_pe_mul_accum.sv
// tb_pe_mul_accum: directed and random checks of pe_mul_accum against a group-sum model
module tb_pe_mul_accum;
  logic CLK = 1'b0;
  logic RESET_N, clk_en, w_en;
  int   n_chk = 0, n_bad = 0;
  always #5 CLK = ~CLK;
  pe_mul_accum_if #(.DATA_W(16), .ACC_W(40), .CNT_W(8)) bus ();
  pe_mul_accum #(.DATA_W(16), .ACC_W(40), .CNT_W(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .clk_en(clk_en), .bus(bus)
  );
  pe_mul_accum_if #(.DATA_W(16), .ACC_W(16), .CNT_W(9)) wbus ();
  pe_mul_accum #(.DATA_W(16), .ACC_W(16), .CNT_W(9)) wdut (
    .CLK(CLK), .RESET_N(RESET_N), .clk_en(w_en), .bus(wbus)
  );
  logic [63:0] m_q[$];
  int          m_len = 0;
  logic        m_ov = 1'b0;
  logic [63:0] m_od = '0;
  int          m_oc = 0;
  localparam logic [63:0] MASK40 = (64'd1 << 40) - 64'd1;
  function automatic logic [63:0] ext_of(input logic [15:0] d, input logic s);
    return s ? {{48{d[15]}}, d} : {48'd0, d};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rn, input logic en, input logic v, input logic [15:0] d,
                      input logic s, input logic [7:0] len, input logic ordy);
    int          el;
    logic        lst, exp_rdy;
    logic [63:0] acc;
    @(negedge CLK);
    RESET_N       = rn;
    clk_en        = en;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_signed = s;
    bus.cfg_len   = len;
    bus.out_ready = ordy;
    #1;
    el      = (m_q.size() == 0) ? ((len == 0) ? 1 : int'(len)) : m_len;
    lst     = (m_q.size() + 1) == el;
    exp_rdy = en & !(lst & m_ov & !ordy);
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_ov});
    if (m_ov) begin
      chk("out_data", {24'd0, bus.out_data}, m_od);
      chk("out_count", {56'd0, bus.out_count}, 64'(m_oc));
    end
    if (!rn) begin
      m_q.delete();
      m_ov = 1'b0;
      m_od = '0;
      m_oc = 0;
    end else if (en) begin
      if (m_ov && ordy) m_ov = 1'b0;
      if (v && exp_rdy) begin
        if (m_q.size() == 0) m_len = el;
        m_q.push_back(ext_of(d, s));
        if (m_q.size() == m_len) begin
          acc = '0;
          foreach (m_q[i]) acc += m_q[i];
          m_ov = 1'b1;
          m_od = acc & MASK40;
          m_oc = m_len;
          m_q.delete();
        end
      end
    end
    @(posedge CLK);
  endtask
  task automatic post(input string tag, input logic [39:0] data, input logic [7:0] cnt);
    #1;
    chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    chk({tag, "_data"}, {24'd0, bus.out_data}, {24'd0, data});
    chk({tag, "_count"}, {56'd0, bus.out_count}, {56'd0, cnt});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int n_acc;
    RESET_N = 1'b0; clk_en = 1'b1; w_en = 1'b1;
    bus.in_valid = 0; bus.in_data = 0; bus.in_signed = 0; bus.cfg_len = 0; bus.out_ready = 1;
    wbus.in_valid = 0; wbus.in_data = 0; wbus.in_signed = 0; wbus.cfg_len = 0; wbus.out_ready = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_data", {24'd0, bus.out_data}, 64'd0);
    chk("rst_count", {56'd0, bus.out_count}, 64'd0);
    chk("rst_ready", {63'd0, bus.in_ready}, 64'd1);
    RESET_N = 1'b1;
    // group of 4 unsigned beats
    for (int i = 1; i <= 4; i++) step(1, 1, 1, 16'(i), 0, 8'd4, 1);
    post("t1", 40'd10, 8'd4);
    step(1, 1, 0, 0, 0, 8'd4, 1);
    // signed pair
    step(1, 1, 1, 16'hFFFF, 1, 8'd2, 1);
    step(1, 1, 1, 16'hFFFE, 1, 8'd2, 1);
    post("t2", 40'hFF_FFFF_FFFD, 8'd2);
    // cfg_len 0 means single-beat groups
    step(1, 1, 1, 16'd7, 0, 8'd0, 1);
    post("t3a", 40'd7, 8'd1);
    step(1, 1, 1, 16'h8000, 1, 8'd0, 1);
    post("t3b", 40'hFF_FFFF_8000, 8'd1);
    step(1, 1, 1, 16'h8000, 0, 8'd0, 1);
    post("t3c", 40'h00_0000_8000, 8'd1);
    step(1, 1, 0, 0, 0, 8'd0, 1);
    // back-pressure on the closing beat, then load and drain on one edge
    step(1, 1, 1, 16'd5, 0, 8'd2, 0);
    step(1, 1, 1, 16'd6, 0, 8'd2, 0);
    step(1, 1, 1, 16'd7, 0, 8'd2, 0);
    step(1, 1, 1, 16'd8, 0, 8'd2, 0);
    #1;
    chk("t4_stall_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("t4_held_data", {24'd0, bus.out_data}, 64'd11);
    step(1, 1, 1, 16'd8, 0, 8'd2, 1);
    post("t4", 40'd15, 8'd2);
    step(1, 1, 0, 0, 0, 8'd2, 1);
    // reset mid-group, then a clean group with a clk_en gap and a cfg_len change
    step(1, 1, 1, 16'd9, 0, 8'd4, 1);
    step(1, 1, 1, 16'd9, 0, 8'd4, 1);
    step(0, 1, 0, 0, 0, 8'd4, 1);
    step(1, 1, 1, 16'd5, 0, 8'd4, 1);
    step(1, 1, 1, 16'd5, 0, 8'd4, 1);
    repeat (3) step(1, 0, 1, 16'd5, 0, 8'd2, 1);
    step(1, 1, 1, 16'd5, 0, 8'd2, 1);
    step(1, 1, 1, 16'd5, 0, 8'd2, 1);
    post("t6", 40'd20, 8'd4);
    step(1, 1, 0, 0, 0, 8'd2, 1);
    step(1, 1, 0, 0, 0, 8'd2, 1);
    // 300 beats of 0xFFFF into a 16-bit accumulator
    n_acc = 0;
    for (int c = 0; c < 400 && n_acc < 300; c++) begin
      @(negedge CLK);
      wbus.in_valid = 1; wbus.in_data = 16'hFFFF; wbus.in_signed = 0;
      wbus.cfg_len = 9'd300; wbus.out_ready = 1;
      #1;
      if (wbus.in_ready) n_acc++;
      @(posedge CLK);
    end
    chk("t5_beats", 64'(n_acc), 64'd300);
    #1;
    chk("t5_valid", {63'd0, wbus.out_valid}, 64'd1);
    chk("t5_data", {48'd0, wbus.out_data}, 64'hFED4);
    chk("t5_count", {55'd0, wbus.out_count}, 64'd300);
    @(negedge CLK);
    wbus.in_valid = 0;
    // random traffic
    for (int c = 0; c < 600; c++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           16'($urandom), 1'($urandom), 8'($urandom_range(0, 5)), $urandom_range(0, 2) != 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
